// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set controller: FSM encoding, field limits
// and the wrap-around step / clamp helpers used on the hour and minute fields.
package time_set_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT_H = 2'd1,
      ST_EDIT_M = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

   localparam logic [4:0] HOUR_MAX = 5'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;

   // Out-of-range preload values fall back to zero.
   function automatic logic [4:0] hour_clamp(input logic [4:0] v);
      logic [4:0] r;
      if (v > HOUR_MAX) begin
         r = 5'd0;
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic logic [5:0] min_clamp(input logic [5:0] v);
      logic [5:0] r;
      if (v > MIN_MAX) begin
         r = 6'd0;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // One step up or down with wrap; an illegal input still lands in range.
   function automatic logic [4:0] hour_step(input logic [4:0] v, input logic up);
      logic [4:0] r;
      if (up) begin
         if (v >= HOUR_MAX) begin
            r = 5'd0;
         end else begin
            r = v + 5'd1;
         end
      end else begin
         if ((v == 5'd0) || (v > HOUR_MAX)) begin
            r = HOUR_MAX;
         end else begin
            r = v - 5'd1;
         end
      end
      return r;
   endfunction

   function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
      logic [5:0] r;
      if (up) begin
         if (v >= MIN_MAX) begin
            r = 6'd0;
         end else begin
            r = v + 6'd1;
         end
      end else begin
         if ((v == 6'd0) || (v > MIN_MAX)) begin
            r = MIN_MAX;
         end else begin
            r = v - 6'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: two-flop synchroniser, level debouncer and a
// single-cycle press pulse on the debounced released->pressed transition.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic clr,
   input  logic key_n,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             press_q, press_d;

   // Next-state: the level flips once the synchronised input has disagreed
   // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = CNT_ZERO;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = CNT_ZERO;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1'b1);
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
      press_d = level_q & ~level_d;
   end

   // Registers; idle state is "released" so nothing fires out of reset.
   always_ff @(posedge clk) begin
      if (!clr) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= CNT_ZERO;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: three debounced keys drive an edit FSM that
// preloads the running time, steps hour then minute, and commits with a
// one-cycle load strobe. The field under edit gets a blink request.
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned BLINK_CYCLES    = 12500000
) (
   input  logic       clk_50,
   input  logic       clr,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   input  logic [4:0] cur_h,
   input  logic [5:0] cur_m,
   output logic [4:0] h,
   output logic [5:0] m,
   output logic       load,
   output logic       editing,
   output logic       blink_h,
   output logic       blink_m
);

   localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_ZERO = BW'(0);

   logic mode_ev, up_ev, dn_ev;
   logic step_up, step_dn, restart_blink;

   state_e          state_q,     state_d;
   logic [4:0]      h_q,         h_d;
   logic [5:0]      m_q,         m_d;
   logic            load_q,      load_d;
   logic            editing_q,   editing_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            phase_q,     phase_d;
   logic            blink_h_q,   blink_h_d;
   logic            blink_m_q,   blink_m_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(clk_50), .clr(clr), .key_n(key_mode), .press(mode_ev)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .clk(clk_50), .clr(clr), .key_n(key_up), .press(up_ev)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
      .clk(clk_50), .clr(clr), .key_n(key_down), .press(dn_ev)
   );

   // Edit FSM: mode advances the state and masks up/down; simultaneous
   // up and down cancel each other.
   always_comb begin
      state_d       = state_q;
      h_d           = h_q;
      m_d           = m_q;
      restart_blink = 1'b0;
      step_up       = up_ev & ~dn_ev;
      step_dn       = dn_ev & ~up_ev;
      case (state_q)
         ST_IDLE: begin
            if (mode_ev) begin
               state_d       = ST_EDIT_H;
               h_d           = hour_clamp(cur_h);
               m_d           = min_clamp(cur_m);
               restart_blink = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EDIT_H: begin
            if (mode_ev) begin
               state_d       = ST_EDIT_M;
               restart_blink = 1'b1;
            end else if (step_up) begin
               h_d = hour_step(h_q, 1'b1);
            end else if (step_dn) begin
               h_d = hour_step(h_q, 1'b0);
            end else begin
               h_d = h_q;
            end
         end
         ST_EDIT_M: begin
            if (mode_ev) begin
               state_d = ST_COMMIT;
            end else if (step_up) begin
               m_d = min_step(m_q, 1'b1);
            end else if (step_dn) begin
               m_d = min_step(m_q, 1'b0);
            end else begin
               m_d = m_q;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Blink timebase and registered outputs, all derived from the next state
   // so they move on the same edge as the state change.
   always_comb begin
      blink_cnt_d = BLINK_ZERO;
      phase_d     = 1'b0;
      if (restart_blink) begin
         blink_cnt_d = BLINK_ZERO;
         phase_d     = 1'b0;
      end else if ((state_d == ST_EDIT_H) || (state_d == ST_EDIT_M)) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = BLINK_ZERO;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1'b1);
            phase_d     = phase_q;
         end
      end else begin
         blink_cnt_d = BLINK_ZERO;
         phase_d     = 1'b0;
      end
      load_d    = (state_d == ST_COMMIT);
      editing_d = (state_d == ST_EDIT_H) || (state_d == ST_EDIT_M);
      blink_h_d = phase_d & (state_d == ST_EDIT_H);
      blink_m_d = phase_d & (state_d == ST_EDIT_M);
   end

   // State, edit value and output registers.
   always_ff @(posedge clk_50) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         h_q         <= 5'd0;
         m_q         <= 6'd0;
         load_q      <= 1'b0;
         editing_q   <= 1'b0;
         blink_cnt_q <= BLINK_ZERO;
         phase_q     <= 1'b0;
         blink_h_q   <= 1'b0;
         blink_m_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         m_q         <= m_d;
         load_q      <= load_d;
         editing_q   <= editing_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         blink_h_q   <= blink_h_d;
         blink_m_q   <= blink_m_d;
      end
   end

   assign h       = h_q;
   assign m       = m_q;
   assign load    = load_q;
   assign editing = editing_q;
   assign blink_h = blink_h_q;
   assign blink_m = blink_m_q;

endmodule
